// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one partial-product step per clock.
// Optional zero-operand fast path enabled by defining SHIFT_ADD_MULTIPLIER_ZERO_BYPASS_EN.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           dbg_state
);

  // Handshake: start is accepted only on an edge where the block is idle
  // (busy=0, done=0); op1/op2 are captured on that edge only. done is a
  // one-cycle pulse marking product valid; product then holds until the
  // next completion. start seen in RUN or DONE is dropped, never queued.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 c_q, c_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH:0]       sum;
  logic                 bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      c_q       <= c_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    c_d       = c_q;
    count_d   = count_q;
    product_d = product_q;
    bypass    = 1'b0;

    // {C,A} after the conditional add; the adder is WIDTH+1 bits so no carry is lost
    sum = q_q[0] ? ({1'b0, a_q} + {1'b0, m_q}) : {c_q, a_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef SHIFT_ADD_MULTIPLIER_ZERO_BYPASS_EN
          bypass = (op1 == '0) || (op2 == '0);
`else
          bypass = 1'b0;
`endif
          m_d     = op1;
          q_d     = op2;
          a_d     = '0;
          c_d     = 1'b0;
          count_d = CW'(WIDTH);
          if (bypass) begin
            product_d = '0;
            state_d   = DONE;
          end else begin
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        // Shift {C,A,Q} right by one; C always shifts in as zero
        a_d     = sum[WIDTH:1];
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        c_d     = 1'b0;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          product_d = {sum[WIDTH:1], sum[0], q_q[WIDTH-1:1]};
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule
